interrupt_judge: RTL and testbench
==================================

# interrupt_judge

Machine-mode interrupt arbiter for the RV64 fetch stage. Every cycle it combines the raw interrupt lines (timer, software, external) with the `mip`/`mie` CSRs, the global `mstatus.MIE` enable and the current privilege mode. It registers a single "take interrupt" flag and the winning interrupt cause. The program counter consumes these outputs to inject an interrupt exception into the IF/ID register in place of the next instruction.

## Interface
Parameters: none. All encodings come from the shared package.

Ports:
- `clk` in 1: the single clock. Everything samples on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `priviledgeMode` in 2 (`u2`): current privilege. 2'b11 = M, 2'b01 = S, 2'b00 = U, 2'b10 reserved.
- `trint` in 1: raw machine timer interrupt line.
- `swint` in 1: raw machine software interrupt line.
- `exint` in 1: raw machine external interrupt line.
- `mstatus` in 64 (`u64`): only bit 3 (MIE) is used.
- `mip` in 64 (`u64`): only bits 3 (MSIP), 7 (MTIP) and 11 (MEIP) are used.
- `mie` in 64 (`u64`): only bits 3 (MSIE), 7 (MTIE) and 11 (MEIE) are used.
- `intEn` out 1: registered. Asserted when an interrupt must be taken.
- `exception` out `exception_t` (64-bit, mcause format): registered. Cause of the winning interrupt.

## Operation
- Per-source pending, computed combinationally:
  - `pe = (exint | mip[11]) & mie[11]`
  - `ps = (swint | mip[3]) & mie[3]`
  - `pt = (trint | mip[7]) & mie[7]`
- Global enable: `ge = (priviledgeMode != 2'b11) | mstatus[3]`.
  - Below M-mode, M interrupts are always globally enabled.
  - The reserved encoding 2'b10 is treated as below M.
- Take decision: `take = ge & (pe | ps | pt)`.
- Fixed priority: external > software > timer.
  - `pe` selects `MACHINE_EXTERNAL_INTERRUPT` (64'h8000_0000_0000_000B).
  - Else `ps` selects `MACHINE_SOFTWARE_INTERRUPT` (64'h8000_0000_0000_0003).
  - Else `pt` selects `MACHINE_TIMER_INTERRUPT` (64'h8000_0000_0000_0007).
- All other bits of `mstatus`, `mip` and `mie` are ignored. Setting them must not change either output.
- `exception` is meaningful only while `intEn` = 1.
  - When `take` = 0, `exception` is loaded with 64'h0.
- The block keeps no pending state of its own. Clearing is the CSR/handler's job:
  - Once `mip`/`mie`/`mstatus` (or a raw line) deassert the condition, `intEn` drops on the next edge.
  - Entering the trap clears MIE, which makes `take` = 0 in M-mode.

## Timing
- Latency: exactly one cycle. Inputs sampled at edge N appear on `intEn`/`exception` after edge N.
- No handshake. Outputs are level signals, re-evaluated every cycle with no enable or stall input.
- Reset values (asynchronous, while `rst` = 0): `intEn` = 0, `exception` = 64'h0. Both hold until the first rising edge after `rst` deasserts.
- Reset asserted mid-operation clears both outputs immediately, without waiting for a clock edge.
- Simultaneous sources:
  - Priority applies within the same cycle.
  - If a higher source rises while a lower one is already being reported, `exception` switches to the higher cause on the next edge.
- A privilege change and a `mstatus` change in the same cycle are both honoured in that cycle's evaluation.

## Structure
- Shared package `common` provides:
  - `u2` and `u64`.
  - `exception_t`: 64-bit enum with `MACHINE_EXTERNAL_INTERRUPT`, `MACHINE_SOFTWARE_INTERRUPT`, `MACHINE_TIMER_INTERRUPT` and `INSTRUCTION_ADDRESS_MISALIGNED` (= 0).
  - Constants `PRIV_M` = 2'b11, `MSTATUS_MIE_BIT` = 3, `MSI_BIT` = 3, `MTI_BIT` = 7, `MEI_BIT` = 11.
- Single module with no sub-modules: a combinational evaluate/priority block feeding one output register.

## Test plan
- Reset: hold `rst` = 0 with `exint` = 1, `mie[11]` = 1, `mstatus[3]` = 1 -> `intEn` = 0 and `exception` = 0 throughout. Release reset -> `intEn` = 1 and `exception` = 64'h8000_0000_0000_000B after the first edge.
- Global enable:
  - Priv = 2'b11, `mstatus` = 0, `trint` = 1, `mie` = 64'h80 -> `intEn` = 0.
  - Same inputs with priv = 2'b00 -> `intEn` = 1, `exception` = 64'h8000_0000_0000_0007.
- Priority: priv = M, `mstatus` = 64'h8, `mie` = 64'h888, `trint` = `swint` = `exint` = 1 -> `exception` = ...000B. Drop `exint` -> ...0003 next cycle. Drop `swint` -> ...0007 next cycle.
- Masking and `mip` path:
  - All raw lines 0, `mip` = 64'h8, `mie` = 64'h8, `mstatus` = 64'h8 -> `intEn` = 1, `exception` = ...0003.
  - `mie` = 64'h80 with the same `mip` -> `intEn` = 0.
- Latency and clear: raise `swint` (enabled) at edge N -> `intEn` = 1 after edge N. Clear `mstatus[3]` at edge N+2 (priv = M) -> `intEn` = 0, `exception` = 0 after edge N+2.
- Asynchronous reset mid-stream: with `intEn` = 1, pulse `rst` low between clock edges -> both outputs go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/common.sv
// rtl/common.sv - shared types and encodings for the machine-mode interrupt path
package common;

   typedef logic [1:0]  u2;
   typedef logic [63:0] u64;

   typedef enum logic [63:0] {
      INSTRUCTION_ADDRESS_MISALIGNED = 64'h0000_0000_0000_0000,
      MACHINE_SOFTWARE_INTERRUPT     = 64'h8000_0000_0000_0003,
      MACHINE_TIMER_INTERRUPT        = 64'h8000_0000_0000_0007,
      MACHINE_EXTERNAL_INTERRUPT     = 64'h8000_0000_0000_000B
   } exception_t;

   localparam u2  PRIV_M          = 2'b11;
   localparam int MSTATUS_MIE_BIT = 3;
   localparam int MSI_BIT         = 3;
   localparam int MTI_BIT         = 7;
   localparam int MEI_BIT         = 11;

endpackage

// File: rtl/interrupt_judge.sv
// rtl/interrupt_judge.sv - registered machine interrupt take/cause arbiter for fetch
module interrupt_judge
   import common::*;
(
   input  logic       clk,
   input  logic       rst,
   input  u2          priviledgeMode,
   input  logic       trint,
   input  logic       swint,
   input  logic       exint,
   input  u64         mstatus,
   input  u64         mip,
   input  u64         mie,
   output logic       intEn,
   output exception_t exception
);

   logic       pe;
   logic       ps;
   logic       pt;
   logic       ge;
   logic       take;
   exception_t next_cause;

   // Only MIE/MSIP/MTIP/MEIP and their enables matter; the rest is folded away here.
   logic unused_bits;
   assign unused_bits = ^{mstatus[63:4], mstatus[2:0],
                          mip[63:12], mip[10:8], mip[6:4], mip[2:0],
                          mie[63:12], mie[10:8], mie[6:4], mie[2:0]};

   always_comb begin
      pe   = (exint | mip[MEI_BIT]) & mie[MEI_BIT];
      ps   = (swint | mip[MSI_BIT]) & mie[MSI_BIT];
      pt   = (trint | mip[MTI_BIT]) & mie[MTI_BIT];
      // Anything below M, including the reserved encoding, cannot mask M interrupts.
      ge   = (priviledgeMode != PRIV_M) | mstatus[MSTATUS_MIE_BIT];
      take = ge & (pe | ps | pt);

      next_cause = INSTRUCTION_ADDRESS_MISALIGNED;
      if (take) begin
         if (pe) begin
            next_cause = MACHINE_EXTERNAL_INTERRUPT;
         end else if (ps) begin
            next_cause = MACHINE_SOFTWARE_INTERRUPT;
         end else begin
            next_cause = MACHINE_TIMER_INTERRUPT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         intEn     <= 1'b0;
         exception <= INSTRUCTION_ADDRESS_MISALIGNED;
      end else begin
         intEn     <= take;
         exception <= next_cause;
      end
   end

endmodule

// File: tb/tb_interrupt_judge.sv
// tb/tb_interrupt_judge.sv - directed scoreboard bench for interrupt_judge
module tb_interrupt_judge;
   import common::*;

   logic       clk;
   logic       rst;
   u2          priv;
   logic       trint;
   logic       swint;
   logic       exint;
   u64         mstatus;
   u64         mip;
   u64         mie;
   logic       int_en;
   exception_t exc;

   typedef struct {
      string       tag;
      logic        en;
      logic [63:0] cause;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   failures;

   localparam logic [63:0] C_EXT  = 64'h8000_0000_0000_000B;
   localparam logic [63:0] C_SW   = 64'h8000_0000_0000_0003;
   localparam logic [63:0] C_TMR  = 64'h8000_0000_0000_0007;
   localparam logic [63:0] C_NONE = 64'h0;

   interrupt_judge dut (
      .clk            (clk),
      .rst            (rst),
      .priviledgeMode (priv),
      .trint          (trint),
      .swint          (swint),
      .exint          (exint),
      .mstatus        (mstatus),
      .mip            (mip),
      .mie            (mie),
      .intEn          (int_en),
      .exception      (exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string tag, input logic en, input logic [63:0] cause);
      logic [63:0] got;
      got = exc;
      checks++;
      assert (int_en === en) else begin
         failures++;
         $error("FAIL %s intEn got=%0b exp=%0b", tag, int_en, en);
      end
      checks++;
      assert (got === cause) else begin
         failures++;
         $error("FAIL %s exception got=%h exp=%h", tag, got, cause);
      end
   endtask

   task automatic set_in(input u2 p, input logic t, input logic s, input logic e,
                         input u64 mst, input u64 ip, input u64 ie);
      priv = p; trint = t; swint = s; exint = e;
      mstatus = mst; mip = ip; mie = ie;
   endtask

   // Push the expectation for the inputs now applied, clock once, then pop and check.
   task automatic step(input string tag, input logic en, input logic [63:0] cause);
      exp_t e;
      e.tag = tag; e.en = en; e.cause = cause;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL %s scoreboard got=empty exp=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         compare(e.tag, e.en, e.cause);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;

      rst = 1'b0;
      set_in(2'b11, 1'b0, 1'b0, 1'b1, 64'h8, 64'h0, 64'h800);
      #2;
      compare("reset_initial", 1'b0, C_NONE);
      step("reset_hold1", 1'b0, C_NONE);
      step("reset_hold2", 1'b0, C_NONE);
      rst = 1'b1;
      #1;
      compare("reset_release_before_edge", 1'b0, C_NONE);
      step("reset_release_edge", 1'b1, C_EXT);

      set_in(2'b11, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h80);
      step("ge_m_mie0", 1'b0, C_NONE);
      priv = 2'b00;
      step("ge_u_mode", 1'b1, C_TMR);
      priv = 2'b10;
      step("ge_reserved", 1'b1, C_TMR);
      priv = 2'b01;
      step("ge_s_mode", 1'b1, C_TMR);

      set_in(2'b11, 1'b1, 1'b1, 1'b1, 64'h8, 64'h0, 64'h888);
      step("prio_all", 1'b1, C_EXT);
      exint = 1'b0;
      step("prio_sw_tmr", 1'b1, C_SW);
      swint = 1'b0;
      step("prio_tmr", 1'b1, C_TMR);
      exint = 1'b1;
      step("prio_ext_rises", 1'b1, C_EXT);

      set_in(2'b11, 1'b0, 1'b0, 1'b0, 64'h8, 64'h8, 64'h8);
      step("mip_msip", 1'b1, C_SW);
      mie = 64'h80;
      step("mip_masked", 1'b0, C_NONE);
      mip = 64'h80;
      step("mip_mtip", 1'b1, C_TMR);

      set_in(2'b11, 1'b0, 1'b0, 1'b0, ~64'h8, ~64'h0, ~64'h888);
      step("ignored_bits_off", 1'b0, C_NONE);
      set_in(2'b11, 1'b0, 1'b1, 1'b0, ~64'h0, ~64'h888, ~64'h888 | 64'h8);
      step("ignored_bits_sw", 1'b1, C_SW);

      set_in(2'b11, 1'b0, 1'b0, 1'b0, 64'h8, 64'h0, 64'h8);
      step("lat_idle", 1'b0, C_NONE);
      swint = 1'b1;
      step("lat_edge_n", 1'b1, C_SW);
      step("lat_edge_n1", 1'b1, C_SW);
      mstatus = 64'h0;
      step("lat_clear_mie", 1'b0, C_NONE);
      mstatus = 64'h8;
      step("lat_reenable", 1'b1, C_SW);

      #2;
      rst = 1'b0;
      #1;
      compare("async_reset_mid", 1'b0, C_NONE);
      #1;
      rst = 1'b1;
      #1;
      compare("async_reset_released", 1'b0, C_NONE);
      step("async_reset_recover", 1'b1, C_SW);

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
